// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_pkg
// Purpose  : Shared widths, FSM state encoding and a saturating-increment
//            helper for the two-requester SRAM arbiter.
// Contents : ADDR_W, DATA_W, REQ_N, CNT_W, state_t, ST_* state constants,
//            sat_inc().
// Revision : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int REQ_N  = 2;
  localparam int CNT_W  = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_rr
// Purpose  : Combinational two-way round-robin picker.
// Ports    : valid [REQ_N-1:0] in  - pending requests (bit N = requester N)
//            last             in  - 1: requester 1 was served last,
//                                    0: requester 0 was served last
//            grant [REQ_N-1:0] out - one-hot grant (zero when no valid)
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter_rr
  import sram_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] valid,
  input  logic             last,
  output logic [REQ_N-1:0] grant
);

  // A lone requester always wins; on a contest the one not served last wins.
  always_comb begin
    grant    = '0;
    grant[0] = valid[0] & (~valid[1] | last);
    grant[1] = valid[1] & (~valid[0] | ~last);
  end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Arbitrates two requesters onto a single-port SRAM with a
//            registered read output (one cycle read latency).
// Ports    : clk, rst (synchronous, active-low)
//            req{0,1}_valid/we/addr/wdata in, req{0,1}_ready out
//            rsp{0,1}_valid/rdata out
//            mem_write, mem_read, mem_addr, mem_wdata out; mem_rdata in
//            busy out (FSM not in IDLE)
//            grant_cnt0/1 out (only with SRAM_ARBITER_STATS_EN defined)
// Options  : SRAM_ARBITER_STATS_EN - adds saturating 16-bit grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef SRAM_ARBITER_STATS_EN
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
`endif
  output logic              busy
);

  state_t            r_state;
  logic              r_owner;   // 0: requester 0, 1: requester 1
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_last;    // 1: requester 1 served last

  logic [REQ_N-1:0]  w_grant;
  logic              w_accept;

  sram_arbiter_rr u_rr (
    .valid ({req1_valid, req0_valid}),
    .last  (r_last),
    .grant (w_grant)
  );

  // Acceptance is only possible in IDLE and never while reset is asserted.
  assign w_accept = rst && (r_state == ST_IDLE) && (|w_grant);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ISSUE;
            r_owner <= w_grant[1];
            r_we    <= w_grant[1] ? req1_we    : req0_we;
            r_addr  <= w_grant[1] ? req1_addr  : req0_addr;
            r_wdata <= w_grant[1] ? req1_wdata : req0_wdata;
            // Writes respond with zero data; reads overwrite this in WAIT.
            r_rdata <= '0;
            r_last  <= w_grant[1];
          end
        end
        ST_ISSUE: r_state <= r_we ? ST_RESP : ST_WAIT;
        ST_WAIT: begin
          // The SRAM registered its output on the ISSUE edge.
          r_rdata <= mem_rdata;
          r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // All outputs are forced low while rst is held, including the cycle in
  // which reset is first sampled.
  assign req0_ready = w_accept & w_grant[0];
  assign req1_ready = w_accept & w_grant[1];
  assign busy       = rst && (r_state != ST_IDLE);
  assign mem_write  = rst && (r_state == ST_ISSUE) &&  r_we;
  assign mem_read   = rst && (r_state == ST_ISSUE) && !r_we;
  assign mem_addr   = rst ? r_addr  : '0;
  assign mem_wdata  = rst ? r_wdata : '0;
  assign rsp0_valid = rst && (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid = rst && (r_state == ST_RESP) &&  r_owner;
  assign rsp0_rdata = rsp0_valid ? r_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? r_rdata : '0;

`ifdef SRAM_ARBITER_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_ready) r_cnt0 <= sat_inc(r_cnt0);
      if (req1_ready) r_cnt1 <= sat_inc(r_cnt1);
    end
  end

  assign grant_cnt0 = rst ? r_cnt0 : '0;
  assign grant_cnt1 = rst ? r_cnt1 : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed self-checking bench for sram_arbiter with a small
//            registered-output SRAM model.
// Options  : SRAM_ARBITER_STATS_EN - also exercises the grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [2:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       mem_write, mem_read;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy;
`ifdef SRAM_ARBITER_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Results of the most recent stream() call.
  int ng, nr0, nr1;
  int gown [8];
  int gcyc [8];

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef SRAM_ARBITER_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .busy       (busy)
  );

  // SRAM model: write on the strobe edge, read data registered on the
  // strobe edge and presented in the following cycle.
  logic [7:0] sram [0:7];
  logic [7:0] sram_q;
  always @(posedge clk) begin
    if (mem_write) sram[mem_addr] <= mem_wdata;
    if (mem_read)  sram_q <= sram[mem_addr];
  end
  assign mem_rdata = sram_q;

  function automatic logic [33:0] outs();
    return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata,
            rsp1_rdata, mem_write, mem_read, mem_addr, mem_wdata, busy};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the given valids until ngrants acceptances are seen (bounded),
  // recording owner and cycle of each grant, then drain the responses.
  task automatic stream(input int ngrants, input logic v0, input logic v1);
    int cyc = 0;
    int bound = 4 * ngrants + 20;
    ng = 0; nr0 = 0; nr1 = 0;
    req0_valid = v0;
    req1_valid = v1;
    while (ng < ngrants && cyc < bound) begin
      @(negedge clk);
      if (req0_ready && req1_ready) check("one_hot_ready", 2'b11, 2'b01);
      if (req0_ready || req1_ready) begin
        if (ng < 8) begin
          gown[ng] = req1_ready ? 1 : 0;
          gcyc[ng] = cyc;
        end
        ng++;
      end
      if (rsp0_valid) nr0++;
      if (rsp1_valid) nr1++;
      @(posedge clk); #1;
      cyc++;
      if (ng == ngrants) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp0_valid) nr0++;
      if (rsp1_valid) nr1++;
      @(posedge clk); #1;
    end
    check("stream_grant_count", ng, ngrants);
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;

    // Reset held: everything low.
    repeat (3) begin
      @(negedge clk); check("reset_outs", outs(), '0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("idle_outs", outs(), '0);
`ifdef SRAM_ARBITER_STATS_EN
      check("idle_cnts", {grant_cnt0, grant_cnt1}, 32'h0);
`endif
      @(posedge clk); #1;
    end

    // req0 write addr 5 = 0xA5, accepted at T.
    req0_valid = 1; req0_we = 1; req0_addr = 3'd5; req0_wdata = 8'hA5;
    @(negedge clk); check("wr_ready", {req0_ready, req1_ready, busy}, 3'b100);
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk);
    check("wr_issue", {mem_write, mem_read, mem_addr, mem_wdata, busy},
          {1'b1, 1'b0, 3'd5, 8'hA5, 1'b1});
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_resp", {rsp0_valid, rsp1_valid, rsp0_rdata, mem_write, mem_read, mem_addr},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5});
    @(posedge clk); #1;

    // req0 read addr 5, expect 0xA5 at T+3.
    req0_valid = 1; req0_we = 0; req0_addr = 3'd5;
    @(negedge clk); check("rd_ready", {req0_ready, req1_ready, busy}, 3'b100);
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk);
    check("rd_issue", {mem_write, mem_read, mem_addr}, {1'b0, 1'b1, 3'd5});
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_wait", {rsp0_valid, mem_write, mem_read, busy, req0_ready}, 5'b00010);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_resp", {rsp0_valid, rsp1_valid, rsp0_rdata}, {1'b1, 1'b0, 8'hA5});
    @(posedge clk); #1;

    // Lone req1 for 3 writes: every grant to req1, back-to-back every 3 cycles.
    req1_we = 1; req1_addr = 3'd3; req1_wdata = 8'h33;
    stream(3, 1'b0, 1'b1);
    check("solo_owners", {gown[0][1:0], gown[1][1:0], gown[2][1:0]}, 6'b01_01_01);
    check("solo_spacing", {gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]}, {32'd3, 32'd3});
    check("solo_rsps", {nr0[7:0], nr1[7:0]}, {8'd0, 8'd3});

    // Both valid, req1 served last: grants 0,1,0,1.
    req0_we = 1; req0_addr = 3'd1; req0_wdata = 8'h11;
    req1_we = 1; req1_addr = 3'd2; req1_wdata = 8'h22;
    stream(4, 1'b1, 1'b1);
    check("rr_owners", {gown[0][1:0], gown[1][1:0], gown[2][1:0], gown[3][1:0]},
          8'b00_01_00_01);
    check("rr_spacing", {gcyc[1] - gcyc[0], gcyc[3] - gcyc[2]}, {32'd3, 32'd3});
    check("rr_rsps", {nr0[7:0], nr1[7:0]}, {8'd2, 8'd2});

    // Reset during WAIT of a read aborts it.
    req0_valid = 1; req0_we = 0; req0_addr = 3'd5;
    @(negedge clk); check("ab_ready", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk); check("ab_issue", mem_read, 1'b1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); check("ab_rst_outs", outs(), '0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (3) begin
      @(negedge clk); check("ab_idle_outs", outs(), '0);
      @(posedge clk); #1;
    end

    // Pointer back to "req1 last": req0 wins the contest; req1 follows.
    req0_valid = 1; req0_we = 0; req0_addr = 3'd5;
    req1_valid = 1; req1_we = 1; req1_addr = 3'd6; req1_wdata = 8'h66;
    @(negedge clk); check("post_rst_rr", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk);
    check("post_rst_issue", {req0_ready, req1_ready, mem_read, mem_addr},
          {1'b0, 1'b0, 1'b1, 3'd5});
    @(posedge clk); #1;
    @(negedge clk); check("post_rst_wait", {rsp0_valid, req1_ready}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_resp", {rsp0_valid, rsp0_rdata, req1_ready}, {1'b1, 8'hA5, 1'b0});
    @(posedge clk); #1;
    @(negedge clk); check("post_rst_req1", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk); #1; req1_valid = 0;
    repeat (4) begin @(posedge clk); #1; end

`ifdef SRAM_ARBITER_STATS_EN
    check("cnt_after_rst", {grant_cnt0, grant_cnt1}, {16'd1, 16'd1});
    req0_we = 1; req0_addr = 3'd0; req0_wdata = 8'h5A;
    stream(16'hFFFD, 1'b1, 1'b0);
    check("cnt_preload", grant_cnt0, 16'hFFFE);
    stream(2, 1'b1, 1'b0);
    check("cnt_saturate", {grant_cnt0, grant_cnt1}, {16'hFFFF, 16'd1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
